mmu_memport_arbiter: RTL and testbench

Two-requester arbiter that shares a single memory port between two MMU interface instances, the instruction-side and data-side `mmu_if`. It registers the granted request into a one-entry output stage and records the owner of every read in an in-order tag queue. It then steers each returning memory response back to the requester that issued it. It sits between the MMU interfaces and the external memory bus.

---
 rtl/mmu_memport_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mmu_memport_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_memport_arbiter.sv
// mmu_memport_arbiter
// Shares one memory port between the instruction-side (requester 0) and
// data-side (requester 1) MMU interfaces. A one-entry stage register feeds
// the memory request bus. An in-order tag queue records the owner of every
// outstanding read so that each response is routed back to the requester
// that issued it.
//
// Build option:
//   MIST1032ISA_MEMARB_FIXED_PRIORITY_EN  defined   -> requester 0 always wins
//                                         undefined -> round-robin arbitration
module mmu_memport_arbiter #(
  parameter int P_QUEUE_DEPTH   = 16,
  parameter int P_QUEUE_DEPTH_N = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  // requester 0 (instruction side)
  input  logic        iREQ0_REQ,
  output logic        oREQ0_LOCK,
  input  logic [1:0]  iREQ0_ORDER,
  input  logic [3:0]  iREQ0_MASK,
  input  logic        iREQ0_RW,
  input  logic [31:0] iREQ0_ADDR,
  input  logic [31:0] iREQ0_DATA,
  output logic        oREQ0_VALID,
  input  logic        iREQ0_LOCK,
  output logic [63:0] oREQ0_DATA,
  output logic        oREQ0_STORE_ACK,
  // requester 1 (data side)
  input  logic        iREQ1_REQ,
  output logic        oREQ1_LOCK,
  input  logic [1:0]  iREQ1_ORDER,
  input  logic [3:0]  iREQ1_MASK,
  input  logic        iREQ1_RW,
  input  logic [31:0] iREQ1_ADDR,
  input  logic [31:0] iREQ1_DATA,
  output logic        oREQ1_VALID,
  input  logic        iREQ1_LOCK,
  output logic [63:0] oREQ1_DATA,
  output logic        oREQ1_STORE_ACK,
  // memory port
  output logic        oMEMORY_REQ,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_LOCK,
  input  logic        iMEMORY_REQ,
  output logic        oMEMORY_LOCK,
  input  logic [63:0] iMEMORY_DATA
);

  localparam int CW  = P_QUEUE_DEPTH_N + 1;  // count width, holds 0..DEPTH
  localparam int OW  = P_QUEUE_DEPTH_N + 2;  // headroom for credit arithmetic

  // stage register
  logic        stage_valid_q, stage_valid_d;
  logic        stage_owner_q, stage_owner_d;
  logic [1:0]  stage_order_q, stage_order_d;
  logic [3:0]  stage_mask_q,  stage_mask_d;
  logic        stage_rw_q,    stage_rw_d;
  logic [31:0] stage_addr_q,  stage_addr_d;
  logic [31:0] stage_data_q,  stage_data_d;

  // tag queue
  logic [P_QUEUE_DEPTH-1:0]   tag_q,    tag_d;
  logic [P_QUEUE_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_QUEUE_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              count_q,  count_d;

  // arbitration
  logic          prio;
  logic          accept, stage_free, q_empty, head, head_lock;
  logic          push, pop, read_ok;
  logic          elig0, elig1, gnt0, gnt1, load;
  logic [OW-1:0] outstanding_next;

`ifdef MIST1032ISA_MEMARB_FIXED_PRIORITY_EN
  assign prio = 1'b0;
`else
  logic prio_q, prio_d;
  assign prio = prio_q;
`endif

  // Handshake, credit and grant decisions for this cycle
  always_comb begin
    accept     = stage_valid_q && !iMEMORY_LOCK;
    stage_free = !stage_valid_q || accept;
    q_empty    = (count_q == '0);
    head       = tag_q[rd_ptr_q];
    head_lock  = head ? iREQ1_LOCK : iREQ0_LOCK;
    pop        = iMEMORY_REQ && !q_empty && !head_lock;
    push       = accept && !stage_rw_q;
    // When the stage is free, a staged read (if any) is moving into the queue
    // this cycle, so outstanding reads after this cycle are count + push - pop.
    outstanding_next = OW'(count_q) + OW'(push) - OW'(pop);
    read_ok    = (outstanding_next < OW'(P_QUEUE_DEPTH));
    elig0      = iREQ0_REQ && (iREQ0_RW || read_ok);
    elig1      = iREQ1_REQ && (iREQ1_RW || read_ok);
    gnt0       = elig0 && (!prio || !elig1);
    gnt1       = elig1 && ( prio || !elig0);
    load       = stage_free && (gnt0 || gnt1);
  end

  // Next state of the stage register: load the winner, else drain or hold
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_owner_d = stage_owner_q;
    stage_order_d = stage_order_q;
    stage_mask_d  = stage_mask_q;
    stage_rw_d    = stage_rw_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    if (load) begin
      stage_valid_d = 1'b1;
      stage_owner_d = gnt1;
      stage_order_d = gnt1 ? iREQ1_ORDER : iREQ0_ORDER;
      stage_mask_d  = gnt1 ? iREQ1_MASK  : iREQ0_MASK;
      stage_rw_d    = gnt1 ? iREQ1_RW    : iREQ0_RW;
      stage_addr_d  = gnt1 ? iREQ1_ADDR  : iREQ0_ADDR;
      stage_data_d  = gnt1 ? iREQ1_DATA  : iREQ0_DATA;
    end else if (accept) begin
      stage_valid_d = 1'b0;
    end
  end

  // Next state of the tag queue: push read owners on accept, pop on delivery
  always_comb begin
    tag_d = tag_q;
    if (push) tag_d[wr_ptr_q] = stage_owner_q;
    wr_ptr_d = wr_ptr_q + P_QUEUE_DEPTH_N'(push);
    rd_ptr_d = rd_ptr_q + P_QUEUE_DEPTH_N'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Stage register flops
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stage_valid_q <= 1'b0;
      stage_owner_q <= 1'b0;
      stage_order_q <= '0;
      stage_mask_q  <= '0;
      stage_rw_q    <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_owner_q <= stage_owner_d;
      stage_order_q <= stage_order_d;
      stage_mask_q  <= stage_mask_d;
      stage_rw_q    <= stage_rw_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
    end
  end

  // Tag queue flops
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      tag_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_q    <= tag_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifndef MIST1032ISA_MEMARB_FIXED_PRIORITY_EN
  // Round-robin pointer: the loser of the last load gets priority next
  always_comb begin
    prio_d = load ? !gnt1 : prio_q;
  end

  // Round-robin pointer flop
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end
`endif

  // Memory request bus comes straight from the stage
  assign oMEMORY_REQ   = stage_valid_q;
  assign oMEMORY_ORDER = stage_order_q;
  assign oMEMORY_MASK  = stage_mask_q;
  assign oMEMORY_RW    = stage_rw_q;
  assign oMEMORY_ADDR  = stage_addr_q;
  assign oMEMORY_DATA  = stage_data_q;

  // A requester that is not asking is not held off while the stage is free,
  // so an idle arbiter shows LOCK low on both sides.
  assign oREQ0_LOCK = !stage_free || (iREQ0_REQ && !gnt0);
  assign oREQ1_LOCK = !stage_free || (iREQ1_REQ && !gnt1);

  assign oREQ0_STORE_ACK = accept && stage_rw_q && !stage_owner_q;
  assign oREQ1_STORE_ACK = accept && stage_rw_q &&  stage_owner_q;

  // Response steering by head tag; spurious responses on an empty queue vanish
  assign oREQ0_VALID  = iMEMORY_REQ && !q_empty && !head && !iREQ0_LOCK;
  assign oREQ1_VALID  = iMEMORY_REQ && !q_empty &&  head && !iREQ1_LOCK;
  assign oREQ0_DATA   = iMEMORY_DATA;
  assign oREQ1_DATA   = iMEMORY_DATA;
  assign oMEMORY_LOCK = !q_empty && head_lock;

endmodule

// File: tb/tb_mmu_memport_arbiter.sv
// Directed testbench for mmu_memport_arbiter (round-robin build).
module tb_mmu_memport_arbiter;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iREQ0_REQ, oREQ0_LOCK, iREQ0_RW, oREQ0_VALID, iREQ0_LOCK, oREQ0_STORE_ACK;
  logic [1:0]  iREQ0_ORDER;
  logic [3:0]  iREQ0_MASK;
  logic [31:0] iREQ0_ADDR, iREQ0_DATA;
  logic [63:0] oREQ0_DATA;
  logic        iREQ1_REQ, oREQ1_LOCK, iREQ1_RW, oREQ1_VALID, iREQ1_LOCK, oREQ1_STORE_ACK;
  logic [1:0]  iREQ1_ORDER;
  logic [3:0]  iREQ1_MASK;
  logic [31:0] iREQ1_ADDR, iREQ1_DATA;
  logic [63:0] oREQ1_DATA;
  logic        oMEMORY_REQ, oMEMORY_RW, iMEMORY_LOCK, iMEMORY_REQ, oMEMORY_LOCK;
  logic [1:0]  oMEMORY_ORDER;
  logic [3:0]  oMEMORY_MASK;
  logic [31:0] oMEMORY_ADDR, oMEMORY_DATA;
  logic [63:0] iMEMORY_DATA;

  int n_checks = 0;
  int n_errors = 0;

  always #5 iCLOCK = ~iCLOCK;

  mmu_memport_arbiter dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iREQ0_REQ(iREQ0_REQ), .oREQ0_LOCK(oREQ0_LOCK), .iREQ0_ORDER(iREQ0_ORDER),
    .iREQ0_MASK(iREQ0_MASK), .iREQ0_RW(iREQ0_RW), .iREQ0_ADDR(iREQ0_ADDR),
    .iREQ0_DATA(iREQ0_DATA), .oREQ0_VALID(oREQ0_VALID), .iREQ0_LOCK(iREQ0_LOCK),
    .oREQ0_DATA(oREQ0_DATA), .oREQ0_STORE_ACK(oREQ0_STORE_ACK),
    .iREQ1_REQ(iREQ1_REQ), .oREQ1_LOCK(oREQ1_LOCK), .iREQ1_ORDER(iREQ1_ORDER),
    .iREQ1_MASK(iREQ1_MASK), .iREQ1_RW(iREQ1_RW), .iREQ1_ADDR(iREQ1_ADDR),
    .iREQ1_DATA(iREQ1_DATA), .oREQ1_VALID(oREQ1_VALID), .iREQ1_LOCK(iREQ1_LOCK),
    .oREQ1_DATA(oREQ1_DATA), .oREQ1_STORE_ACK(oREQ1_STORE_ACK),
    .oMEMORY_REQ(oMEMORY_REQ), .oMEMORY_ORDER(oMEMORY_ORDER), .oMEMORY_MASK(oMEMORY_MASK),
    .oMEMORY_RW(oMEMORY_RW), .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA),
    .iMEMORY_LOCK(iMEMORY_LOCK), .iMEMORY_REQ(iMEMORY_REQ), .oMEMORY_LOCK(oMEMORY_LOCK),
    .iMEMORY_DATA(iMEMORY_DATA)
  );

  typedef struct {
    bit          rst;
    bit          r0, w0;
    logic [31:0] a0;
    bit          r1, w1;
    logic [31:0] a1;
    bit          mlk, mreq;
    logic [63:0] md;
    bit          l0, l1;
    bit          e_lk0, e_lk1, e_mreq;
    logic [31:0] e_addr;
    bit          e_v0, e_v1, e_sa0, e_sa1, e_mlk;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  function automatic vec_t mk(bit rst, bit r0, bit w0, logic [31:0] a0,
                              bit r1, bit w1, logic [31:0] a1,
                              bit mlk, bit mreq, logic [63:0] md, bit l0, bit l1,
                              bit e_lk0, bit e_lk1, bit e_mreq, logic [31:0] e_addr,
                              bit e_v0, bit e_v1, bit e_sa0, bit e_sa1, bit e_mlk);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.mlk = mlk; v.mreq = mreq; v.md = md; v.l0 = l0; v.l1 = l1;
    v.e_lk0 = e_lk0; v.e_lk1 = e_lk1; v.e_mreq = e_mreq; v.e_addr = e_addr;
    v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_sa0 = e_sa0; v.e_sa1 = e_sa1; v.e_mlk = e_mlk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0,
                       input bit r1, input bit w1, input logic [31:0] a1);
    iREQ0_REQ = r0; iREQ0_RW = w0; iREQ0_ADDR = a0; iREQ0_DATA = a0 + 32'd1;
    iREQ1_REQ = r1; iREQ1_RW = w1; iREQ1_ADDR = a1; iREQ1_DATA = a1 + 32'd1;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0);
    iMEMORY_LOCK = 0; iMEMORY_REQ = 0; iMEMORY_DATA = '0;
    iREQ0_LOCK = 0; iREQ1_LOCK = 0;
  endtask

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    inRESET = 1'b0;
    step();
    inRESET = 1'b1;
  endtask

  localparam logic [63:0] D0 = 64'hD0D0_0000_1111_2222;
  localparam logic [63:0] D1 = 64'hD1D1_3333_4444_5555;
  localparam logic [63:0] D2 = 64'hD2D2_6666_7777_8888;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int loads;
    iREQ0_ORDER = 2'b10; iREQ0_MASK = 4'h3;
    iREQ1_ORDER = 2'b10; iREQ1_MASK = 4'hC;
    idle_inputs();
    inRESET = 1'b0;
    step(); step();
    inRESET = 1'b1;
    #2;
    chk("rst mem_req",  oMEMORY_REQ, 0);
    chk("rst mem_addr", oMEMORY_ADDR, 0);
    chk("rst mem_data", oMEMORY_DATA, 0);
    chk("rst mem_fld",  {oMEMORY_ORDER, oMEMORY_MASK, oMEMORY_RW}, 0);
    chk("rst valid",    {oREQ0_VALID, oREQ1_VALID}, 0);
    chk("rst sack",     {oREQ0_STORE_ACK, oREQ1_STORE_ACK}, 0);
    chk("rst lock",     {oREQ0_LOCK, oREQ1_LOCK}, 0);
    chk("rst mem_lock", oMEMORY_LOCK, 0);
    step();

    // rst r0 w0 a0     r1 w1 a1     mlk mreq md l0 l1 | lk0 lk1 mreq addr  v0 v1 sa0 sa1 mlk
    vt[0]  = mk(0, 1,0,'h400, 1,0,'h500, 0,0,0, 0,0,  0,1,0,'h000, 0,0,0,0,0);
    vt[1]  = mk(0, 1,0,'h400, 1,0,'h500, 0,0,0, 0,0,  1,0,1,'h400, 0,0,0,0,0);
    vt[2]  = mk(0, 1,0,'h400, 1,0,'h500, 0,0,0, 0,0,  0,1,1,'h500, 0,0,0,0,0);
    vt[3]  = mk(0, 1,0,'h400, 1,0,'h500, 0,0,0, 0,0,  1,0,1,'h400, 0,0,0,0,0);
    vt[4]  = mk(0, 1,0,'h400, 1,0,'h500, 0,0,0, 0,0,  0,1,1,'h500, 0,0,0,0,0);
    vt[5]  = mk(1, 1,0,'h100, 1,0,'h200, 0,1,D2,1,0,  0,1,0,'h000, 0,0,0,0,0);
    vt[6]  = mk(0, 1,1,'h300, 1,0,'h200, 0,0,0, 0,0,  1,0,1,'h100, 0,0,0,0,0);
    vt[7]  = mk(0, 1,1,'h300, 0,0,'h000, 0,0,0, 0,0,  0,0,1,'h200, 0,0,0,0,0);
    vt[8]  = mk(0, 0,0,'h000, 0,0,'h000, 0,1,D0,0,0,  0,0,1,'h300, 1,0,1,0,0);
    vt[9]  = mk(0, 0,0,'h000, 0,0,'h000, 0,1,D1,0,1,  0,0,0,'h300, 0,0,0,0,1);
    vt[10] = mk(0, 0,0,'h000, 0,0,'h000, 0,1,D1,0,0,  0,0,0,'h300, 0,1,0,0,0);
    vt[11] = mk(0, 0,0,'h000, 0,0,'h000, 0,1,D2,1,1,  0,0,0,'h300, 0,0,0,0,0);
    vt[12] = mk(0, 0,0,'h000, 0,0,'h000, 0,0,0, 0,0,  0,0,0,'h300, 0,0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst) do_reset();
      drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].r1, vt[i].w1, vt[i].a1);
      iMEMORY_LOCK = vt[i].mlk; iMEMORY_REQ = vt[i].mreq; iMEMORY_DATA = vt[i].md;
      iREQ0_LOCK = vt[i].l0; iREQ1_LOCK = vt[i].l1;
      #2;
      if (vt[i].r0) chk($sformatf("v%0d lock0", i), oREQ0_LOCK, vt[i].e_lk0);
      if (vt[i].r1) chk($sformatf("v%0d lock1", i), oREQ1_LOCK, vt[i].e_lk1);
      chk($sformatf("v%0d mem_req", i),  oMEMORY_REQ, vt[i].e_mreq);
      chk($sformatf("v%0d mem_addr", i), oMEMORY_ADDR, vt[i].e_addr);
      chk($sformatf("v%0d valid0", i),   oREQ0_VALID, vt[i].e_v0);
      chk($sformatf("v%0d valid1", i),   oREQ1_VALID, vt[i].e_v1);
      chk($sformatf("v%0d sack0", i),    oREQ0_STORE_ACK, vt[i].e_sa0);
      chk($sformatf("v%0d sack1", i),    oREQ1_STORE_ACK, vt[i].e_sa1);
      chk($sformatf("v%0d mem_lock", i), oMEMORY_LOCK, vt[i].e_mlk);
      if (vt[i].e_v0) chk($sformatf("v%0d data0", i), oREQ0_DATA, vt[i].md);
      if (vt[i].e_v1) chk($sformatf("v%0d data1", i), oREQ1_DATA, vt[i].md);
      step();
    end

    // Credit exhaustion: 16 reads go out, the 17th waits; writes still pass
    do_reset();
    drive(1, 0, 'h1000, 0, 0, 0);
    loads = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (!oREQ0_LOCK) loads++;
      step();
    end
    chk("credit loads", loads, 16);
    #2;
    chk("credit full lock0", oREQ0_LOCK, 1);
    chk("credit full mem_req", oMEMORY_REQ, 0);
    step();
    drive(1, 0, 'h1000, 1, 1, 'h300);
    #2;
    chk("credit wr lock1", oREQ1_LOCK, 0);
    chk("credit wr lock0", oREQ0_LOCK, 1);
    step();
    drive(1, 0, 'h1000, 0, 0, 0);
    #2;
    chk("credit wr mem_req", oMEMORY_REQ, 1);
    chk("credit wr addr", oMEMORY_ADDR, 'h300);
    chk("credit wr rw", oMEMORY_RW, 1);
    chk("credit wr sack1", oREQ1_STORE_ACK, 1);
    chk("credit wr sack0", oREQ0_STORE_ACK, 0);
    chk("credit wr lock0", oREQ0_LOCK, 1);
    step();
    iMEMORY_REQ = 1; iMEMORY_DATA = D0;
    #2;
    chk("credit rsp valid0", oREQ0_VALID, 1);
    chk("credit rsp lock0", oREQ0_LOCK, 0);
    chk("credit rsp mem_req", oMEMORY_REQ, 0);
    step();
    iMEMORY_REQ = 0;
    #2;
    chk("credit reissue mem_req", oMEMORY_REQ, 1);
    chk("credit reissue addr", oMEMORY_ADDR, 'h1000);
    chk("credit reissue rw", oMEMORY_RW, 0);
    chk("credit refull lock0", oREQ0_LOCK, 1);
    step();

    // Memory back-pressure: stage must stay frozen while iMEMORY_LOCK is high
    do_reset();
    drive(1, 0, 'h700, 0, 0, 0);
    #2;
    chk("hold first lock0", oREQ0_LOCK, 0);
    step();
    iMEMORY_LOCK = 1;
    drive(1, 0, 'h710, 1, 0, 'h720);
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("hold%0d addr", c), oMEMORY_ADDR, 'h700);
      chk($sformatf("hold%0d lock0", c), oREQ0_LOCK, 1);
      chk($sformatf("hold%0d lock1", c), oREQ1_LOCK, 1);
      chk($sformatf("hold%0d mem_req", c), oMEMORY_REQ, 1);
      if (c == 0) begin
        chk("hold data", oMEMORY_DATA, 'h701);
        chk("hold order", oMEMORY_ORDER, 2'b10);
        chk("hold mask", oMEMORY_MASK, 4'h3);
        chk("hold rw", oMEMORY_RW, 0);
      end
      step();
    end
    iMEMORY_LOCK = 0;
    #2;
    chk("release lock1", oREQ1_LOCK, 0);
    chk("release lock0", oREQ0_LOCK, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("release addr", oMEMORY_ADDR, 'h720);
    chk("release mask", oMEMORY_MASK, 4'hC);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
